smart_mac_guard: RTL and testbench
==================================

SMART_MAC_GUARD -- requirements
Module: smart_mac

Interface
REQ-001 SHALL expose parameter SIZE_MEM_ADDR, default 4: key-store index width; depth = 2^SIZE_MEM_ADDR words.
REQ-002 SHALL expose parameter LOW_SAFE, default 8: first word address of the protected key region (inclusive).
REQ-003 SHALL expose parameter HIGH_SAFE, default 16: end of the key region (exclusive).
REQ-004 SHALL expose parameter LOW_CODE, default 24: trusted-code entry point and region start (inclusive).
REQ-005 SHALL expose parameter HIGH_CODE, default 32: trusted-code region end (exclusive).
REQ-006 SHALL expose parameter KEY_SEED, default 16'hA5C3: key word i = KEY_SEED + i (mod 2^16).
REQ-007 SHALL expose parameter RST_PULSE, default 4: cycles that the reset output is held after a violation.
REQ-008 Ports: mclk  in  1  sole clock; all state changes on its rising edge.
REQ-009 Ports: reset_n  in  1  asynchronous active-low reset.
REQ-010 Ports: mem_addr  in  16  data-bus word address; narrower drivers are zero-extended.
REQ-011 Ports: mem_din  in  16  read data from main memory.
REQ-012 Ports: ins_addr  in  16  current instruction address (PC).
REQ-013 Ports: disable_debug  in  1  high = debug interface disabled.
REQ-014 Ports: mem_dout  out  16  data returned to CPU.
REQ-015 Ports: in_safe_area  out  1  access currently targets the key region.
REQ-016 Ports: reset  out  1  active-high system reset request to the CPU.

Function
REQ-017 in_safe_area SHALL be combinational: 1 iff LOW_SAFE <= mem_addr < HIGH_SAFE.
REQ-018 pc_in_code SHALL be combinational: 1 iff LOW_CODE <= ins_addr < HIGH_CODE.
REQ-019 Key access SHALL be legal iff in_safe_area AND pc_in_code AND disable_debug = 1.
REQ-020 An entry violation SHALL occur when pc_in_code = 1, the registered previous-cycle pc_in_code = 0 and ins_addr != LOW_CODE.
REQ-021 An access violation SHALL occur when in_safe_area = 1 and the key access is not legal.
REQ-022 mem_dout SHALL be registered with one-cycle latency: key word[(mem_addr - LOW_SAFE) truncated to SIZE_MEM_ADDR bits] on a legal key access; 16'h0000 on a violating access; mem_din otherwise.
REQ-023 On any violation, reset SHALL assert on the next rising edge and stay high for exactly RST_PULSE cycles.
REQ-024 A violation occurring while reset is high SHALL reload the counter to RST_PULSE, extending the pulse.
REQ-025 The key store SHALL be read-only; mem_din SHALL never alter key words.
REQ-026 Addresses HIGH_SAFE-1 and LOW_CODE SHALL be inside their regions; HIGH_SAFE and HIGH_CODE SHALL be outside.
REQ-027 Access and entry violations in the same cycle SHALL produce a single pulse.

Reset
REQ-028 While reset_n = 0: mem_dout = 0, reset = 0, pulse counter = 0, previous pc_in_code = 1 (no false entry violation on release).
REQ-029 Deasserting reset_n mid-pulse SHALL resume normal operation immediately with reset = 0.

Structure
REQ-030 Region bounds, KEY_SEED and the address/data width constants SHALL live in a shared package, smart_mac_pkg.
REQ-031 The key-store ROM SHALL be a separate sub-module, smart_key_rom (index in, 16-bit word out, combinational).

Verification
REQ-032 After reset_n release: mem_addr=0, ins_addr=0, mem_din=16'hFFFF -> mem_dout=16'hFFFF after 1 cycle; reset=0; in_safe_area=0.
REQ-033 mem_addr=8, ins_addr=0, disable_debug=0 -> in_safe_area=1 immediately; mem_dout=0 and reset=1 next edge, held 4 cycles.
REQ-034 ins_addr=24, disable_debug=1, mem_addr=9 -> mem_dout=16'hA5C4 next edge; reset stays 0.
REQ-035 Same as REQ-034 with disable_debug=0 -> mem_dout=0; 4-cycle reset pulse.
REQ-036 ins_addr steps 0 -> 26 -> reset pulse; ins_addr steps 0 -> 24 -> no pulse.
REQ-037 mem_addr=16 and mem_addr=7 -> in_safe_area=0, mem_dout=mem_din; second violation during a pulse -> pulse extended to 4 cycles from that violation.

Source files
------------

// File: rtl/smart_mac_pkg.sv
// Shared constants and types for the smart MAC key guard: bus widths,
// default region bounds, key seed and the region-decode helper.
package smart_mac_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    localparam int unsigned SIZE_MEM_ADDR_DEF = 4;
    localparam int unsigned LOW_SAFE_DEF      = 8;
    localparam int unsigned HIGH_SAFE_DEF     = 16;
    localparam int unsigned LOW_CODE_DEF      = 24;
    localparam int unsigned HIGH_CODE_DEF     = 32;
    localparam int unsigned RST_PULSE_DEF     = 4;

    localparam logic [DATA_W-1:0] KEY_SEED_DEF = 16'hA5C3;

    // The two independent ways a cycle can break the guard's rules.
    typedef struct packed {
        logic entry;   // jumped into trusted code somewhere other than its entry point
        logic access;  // touched the key region without being allowed to
    } viol_t;

    // Half-open region test lo <= addr < hi, done at 32 bits so that a bound
    // of 2^16 still works as an exclusive upper limit.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       lo,
                                      input int unsigned       hi);
        return ({16'd0, addr} >= lo) && ({16'd0, addr} < hi);
    endfunction

endpackage

// File: rtl/smart_key_rom.sv
// Read-only key store: word i = KEY_SEED + i (mod 2^16), combinational read.
module smart_key_rom
    import smart_mac_pkg::*;
#(
    parameter int unsigned       SIZE_MEM_ADDR = SIZE_MEM_ADDR_DEF,
    parameter logic [DATA_W-1:0] KEY_SEED      = KEY_SEED_DEF
) (
    input  logic [SIZE_MEM_ADDR-1:0] i_index,
    output logic [DATA_W-1:0]        o_word
);

    // NOTE: the key words are a pure function of the index, so there is no
    // storage here to reset or to write; the store cannot be altered by the bus.
    assign o_word = KEY_SEED + DATA_W'(i_index);

endmodule

// File: rtl/smart_mac_guard.sv
// Key-region guard: decodes the data and instruction addresses, serves key
// words only to trusted code with debug disabled, and raises a stretched
// CPU reset pulse on any entry or access violation.
module smart_mac_guard
    import smart_mac_pkg::*;
#(
    parameter int unsigned       SIZE_MEM_ADDR = SIZE_MEM_ADDR_DEF,
    parameter int unsigned       LOW_SAFE      = LOW_SAFE_DEF,
    parameter int unsigned       HIGH_SAFE     = HIGH_SAFE_DEF,
    parameter int unsigned       LOW_CODE      = LOW_CODE_DEF,
    parameter int unsigned       HIGH_CODE     = HIGH_CODE_DEF,
    parameter logic [DATA_W-1:0] KEY_SEED      = KEY_SEED_DEF,
    parameter int unsigned       RST_PULSE     = RST_PULSE_DEF
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_din,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic              disable_debug,
    output logic [DATA_W-1:0] mem_dout,
    output logic              in_safe_area,
    output logic              reset
);

    localparam int unsigned CNT_W = $clog2(RST_PULSE + 1);

    logic                     w_in_safe;
    logic                     w_pc_in_code;
    logic                     w_legal;
    viol_t                    w_viol;
    logic [SIZE_MEM_ADDR-1:0] w_key_index;
    logic [DATA_W-1:0]        w_key_word;
    logic [DATA_W-1:0]        w_dout_nxt;

    logic [DATA_W-1:0]        r_dout;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_prev_pc_in_code;

    assign w_in_safe    = in_range(mem_addr, LOW_SAFE, HIGH_SAFE);
    assign w_pc_in_code = in_range(ins_addr, LOW_CODE, HIGH_CODE);
    assign w_legal      = w_in_safe && w_pc_in_code && disable_debug;

    // Entering trusted code is only allowed through its first instruction.
    assign w_viol.entry  = w_pc_in_code && !r_prev_pc_in_code &&
                           (ins_addr != ADDR_W'(LOW_CODE));
    assign w_viol.access = w_in_safe && !w_legal;

    // Offset into the key region; wraps modulo the key-store depth.
    assign w_key_index = SIZE_MEM_ADDR'(mem_addr - ADDR_W'(LOW_SAFE));

    smart_key_rom #(
        .SIZE_MEM_ADDR (SIZE_MEM_ADDR),
        .KEY_SEED      (KEY_SEED)
    ) u_key_rom (
        .i_index (w_key_index),
        .o_word  (w_key_word)
    );

    // Select next read data: key on a clean legal access, zero for any key-region
    // access in a violating cycle, pass-through of main memory otherwise.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // variable unassigned, which would otherwise infer a latch.
        w_dout_nxt = mem_din;
        if (w_in_safe) begin
            w_dout_nxt = (w_legal && !w_viol.entry) ? w_key_word : '0;
        end
    end

    // Register read data and the previous-cycle trusted-code flag.
    always_ff @(posedge mclk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            r_dout            <= '0;
            r_prev_pc_in_code <= 1'b1;
        end else begin
            r_dout            <= w_dout_nxt;
            r_prev_pc_in_code <= w_pc_in_code;
        end
    end

    // Reset-pulse counter: any violation (re)loads it, otherwise it drains to zero.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (|w_viol) begin
            r_cnt <= CNT_W'(RST_PULSE);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign mem_dout     = r_dout;
    assign in_safe_area = w_in_safe;
    assign reset        = (r_cnt != '0);

endmodule

// File: tb/tb_smart_mac_guard.sv
// Self-checking bench for smart_mac_guard: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences; registered results go
// through a scoreboard queue and are compared one cycle after driving.
module tb_smart_mac_guard;

    logic        mclk;
    logic        reset_n;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] ins_addr;
    logic        disable_debug;
    logic [15:0] mem_dout;
    logic        in_safe_area;
    logic        reset;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] ma;
        logic [15:0] din;
        logic [15:0] ia;
        logic        dd;
        logic        exp_safe;
        logic [15:0] exp_dout;
        logic        chk_dout;
        logic        exp_rst;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic        chk_dout;
        logic        rst;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[25];

    smart_mac_guard dut (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .ins_addr      (ins_addr),
        .disable_debug (disable_debug),
        .mem_dout      (mem_dout),
        .in_safe_area  (in_safe_area),
        .reset         (reset)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // flag, queue the registered expectation, then compare after the rising edge.
    task automatic apply(input logic [15:0] ma, input logic [15:0] din,
                         input logic [15:0] ia, input logic dd,
                         input logic exp_safe, input logic [15:0] exp_dout,
                         input logic chk_dout, input logic exp_rst,
                         input string name);
        exp_t e;
        @(negedge mclk);
        mem_addr      = ma;
        mem_din       = din;
        ins_addr      = ia;
        disable_debug = dd;
        #1;
        check({name, ".in_safe_area"}, {15'd0, in_safe_area}, {15'd0, exp_safe});
        sb_q.push_back('{dout: exp_dout, chk_dout: chk_dout, rst: exp_rst, name: name});
        @(posedge mclk);
        #1;
        if (sb_q.size() == 0) begin
            check({name, ".scoreboard_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.chk_dout) check({e.name, ".mem_dout"}, mem_dout, e.dout);
            check({e.name, ".reset"}, {15'd0, reset}, {15'd0, e.rst});
        end
    endtask

    initial begin
        // ma, din, ia, dd, safe, dout, chk_dout, rst-after-edge
        vecs[0]  = '{16'h0000, 16'hFFFF, 16'd0,  1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0}; // idle pass-through
        vecs[1]  = '{16'd9,    16'h1234, 16'd24, 1'b1, 1'b1, 16'hA5C4, 1'b1, 1'b0}; // legal key[1]
        vecs[2]  = '{16'd15,   16'h1234, 16'd25, 1'b1, 1'b1, 16'hA5CA, 1'b1, 1'b0}; // HIGH_SAFE-1 inside
        vecs[3]  = '{16'd8,    16'h1234, 16'd31, 1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0}; // HIGH_CODE-1 inside
        vecs[4]  = '{16'd16,   16'hBEEF, 16'd31, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0}; // HIGH_SAFE outside
        vecs[5]  = '{16'd7,    16'h7777, 16'd31, 1'b1, 1'b0, 16'h7777, 1'b1, 1'b0}; // below LOW_SAFE
        vecs[6]  = '{16'd12,   16'h5555, 16'd32, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1}; // PC at HIGH_CODE: violation
        vecs[7]  = '{16'd0,    16'h1111, 16'd0,  1'b1, 1'b0, 16'h1111, 1'b1, 1'b1};
        vecs[8]  = '{16'd0,    16'h2222, 16'd0,  1'b1, 1'b0, 16'h2222, 1'b1, 1'b1};
        vecs[9]  = '{16'd0,    16'h3333, 16'd0,  1'b1, 1'b0, 16'h3333, 1'b1, 1'b1};
        vecs[10] = '{16'd0,    16'h4444, 16'd0,  1'b1, 1'b0, 16'h4444, 1'b1, 1'b0}; // pulse over after 4
        vecs[11] = '{16'h8000, 16'hCAFE, 16'd0,  1'b1, 1'b0, 16'hCAFE, 1'b1, 1'b0};
        vecs[12] = '{16'd9,    16'h0000, 16'd24, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1}; // debug enabled
        vecs[13] = '{16'd0,    16'hAAAA, 16'd24, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b1};
        vecs[14] = '{16'd0,    16'hAAAB, 16'd24, 1'b1, 1'b0, 16'hAAAB, 1'b1, 1'b1};
        vecs[15] = '{16'd0,    16'hAAAC, 16'd24, 1'b1, 1'b0, 16'hAAAC, 1'b1, 1'b1};
        vecs[16] = '{16'd0,    16'hAAAD, 16'd24, 1'b1, 1'b0, 16'hAAAD, 1'b1, 1'b0};
        vecs[17] = '{16'd0,    16'h0001, 16'd0,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[18] = '{16'd0,    16'h0002, 16'd26, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1}; // entry at 26
        vecs[19] = '{16'd0,    16'h0003, 16'd27, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1};
        vecs[20] = '{16'd0,    16'h0004, 16'd27, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1};
        vecs[21] = '{16'd0,    16'h0005, 16'd27, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b1};
        vecs[22] = '{16'd0,    16'h0006, 16'd27, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0};
        vecs[23] = '{16'd0,    16'h0007, 16'd0,  1'b1, 1'b0, 16'h0007, 1'b1, 1'b0};
        vecs[24] = '{16'd0,    16'h0008, 16'd24, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0}; // proper entry

        reset_n       = 1'b0;
        mem_addr      = '0;
        mem_din       = '0;
        ins_addr      = '0;
        disable_debug = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("rst.mem_dout", mem_dout, 16'h0000);
        check("rst.reset", {15'd0, reset}, 16'd0);
        @(negedge mclk);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i].ma, vecs[i].din, vecs[i].ia, vecs[i].dd, vecs[i].exp_safe,
                  vecs[i].exp_dout, vecs[i].chk_dout, vecs[i].exp_rst, $sformatf("vec%0d", i));
        end

        // Second violation mid-pulse reloads the counter.
        apply(16'd8, 16'h0A0A, 16'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "ext.v1");
        apply(16'd0, 16'h0B0B, 16'd0, 1'b1, 1'b0, 16'h0B0B, 1'b1, 1'b1, "ext.c1");
        apply(16'd8, 16'h0C0C, 16'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "ext.v2");
        apply(16'd0, 16'h0D0D, 16'd0, 1'b1, 1'b0, 16'h0D0D, 1'b1, 1'b1, "ext.c2");
        apply(16'd0, 16'h0E0E, 16'd0, 1'b1, 1'b0, 16'h0E0E, 1'b1, 1'b1, "ext.c3");
        apply(16'd0, 16'h0F0F, 16'd0, 1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b1, "ext.c4");
        apply(16'd0, 16'h1010, 16'd0, 1'b1, 1'b0, 16'h1010, 1'b1, 1'b0, "ext.end");

        // Entry and access violation together give one 4-cycle pulse.
        apply(16'd10, 16'h2020, 16'd26, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "dual.v");
        apply(16'd0,  16'h2121, 16'd26, 1'b1, 1'b0, 16'h2121, 1'b1, 1'b1, "dual.c1");
        apply(16'd0,  16'h2222, 16'd26, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b1, "dual.c2");
        apply(16'd0,  16'h2323, 16'd26, 1'b1, 1'b0, 16'h2323, 1'b1, 1'b1, "dual.c3");
        apply(16'd0,  16'h2424, 16'd26, 1'b1, 1'b0, 16'h2424, 1'b1, 1'b0, "dual.end");

        // reset_n asserted mid-pulse clears outputs at once; release resumes
        // with no false entry violation even with the PC inside trusted code.
        apply(16'd8, 16'h3030, 16'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "mid.v");
        apply(16'd0, 16'h3131, 16'd0, 1'b1, 1'b0, 16'h3131, 1'b1, 1'b1, "mid.c1");
        @(negedge mclk);
        reset_n  = 1'b0;
        ins_addr = 16'd26;
        #1;
        check("mid.async_reset", {15'd0, reset}, 16'd0);
        check("mid.async_dout", mem_dout, 16'h0000);
        @(negedge mclk);
        reset_n = 1'b1;
        apply(16'd0, 16'h9999, 16'd26, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, "mid.resume");
        apply(16'd9, 16'h9998, 16'd27, 1'b1, 1'b1, 16'hA5C4, 1'b1, 1'b0, "mid.key");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
